// File: rtl/ap_pkg.sv
// Shared opcode definitions for the accumulator-pointer command path.
// Imported by the instruction decoder and the pointer unit.
package ap_pkg;

  localparam int unsigned AP_OP_W = 3;

  localparam logic [AP_OP_W-1:0] AP_NOP     = 3'd0;
  localparam logic [AP_OP_W-1:0] AP_LOAD    = 3'd1;
  localparam logic [AP_OP_W-1:0] AP_INC     = 3'd2;
  localparam logic [AP_OP_W-1:0] AP_DEC     = 3'd3;
  localparam logic [AP_OP_W-1:0] AP_PUSH    = 3'd4;
  localparam logic [AP_OP_W-1:0] AP_POP     = 3'd5;
  localparam logic [AP_OP_W-1:0] AP_XCHG    = 3'd6;
  localparam logic [AP_OP_W-1:0] AP_CLR_ERR = 3'd7;

endpackage

// File: rtl/ap_ptr_unit_if.sv
// Command/status bundle between the instruction decoder (master) and the
// pointer unit (slave).
interface ap_ptr_unit_if
  import ap_pkg::*;
#(
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned STACK_DEPTH = 4
);

  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

  logic               cmd_valid;
  logic [AP_OP_W-1:0] cmd_op;
  logic [SEL_W-1:0]   cmd_data;
  logic [SEL_W-1:0]   ap_sel;
  logic [CNT_W-1:0]   stack_cnt;
  logic               stack_full;
  logic               stack_empty;
  logic               err;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  ap_sel, stack_cnt, stack_full, stack_empty, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output ap_sel, stack_cnt, stack_full, stack_empty, err
  );

endinterface

// File: rtl/ap_lifo.sv
// Saved-pointer LIFO: storage plus occupancy counter. Requests that would
// overflow or underflow are ignored here; error reporting belongs to the caller.
module ap_lifo #(
  parameter int unsigned Width = 3,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW  = $clog2(Depth + 1),
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             replace_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] top_o,
  output logic [CntW-1:0]  cnt_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [AddrW-1:0] wr_idx, top_idx;

  assign wr_idx  = AddrW'(cnt_q);
  assign top_idx = AddrW'(cnt_q - CntW'(1));

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign top_o   = mem_q[top_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !full_o) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop_i && !empty_o) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_idx] <= wdata_i;
    end else if (replace_i && !empty_o) begin
      mem_q[top_idx] <= wdata_i;
    end
  end

endmodule

// File: rtl/ap_ptr_unit.sv
// Register-select pointer with wrap/saturate stepping, a save stack for nested
// pointer contexts, and a sticky error flag for stack misuse.
module ap_ptr_unit
  import ap_pkg::*;
#(
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned STACK_DEPTH = 4,
  parameter bit          WRAP        = 1'b1,
  parameter int unsigned RESET_SEL   = 0
) (
  input logic          clk,
  input logic          rst,
  ap_ptr_unit_if.slave bus
);

  localparam logic [SEL_W-1:0] SelMax = {SEL_W{1'b1}};

  logic [SEL_W-1:0] sel_q, sel_d;
  logic             err_q, err_d;
  logic             push, pop, xchg;
  logic [SEL_W-1:0] top;
  logic             full, empty;

  always_comb begin
    sel_d = sel_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    xchg  = 1'b0;
    if (bus.cmd_valid) begin
      case (bus.cmd_op)
        AP_LOAD: sel_d = bus.cmd_data;
        AP_INC: begin
          if (WRAP || sel_q != SelMax) sel_d = sel_q + 1'b1;
        end
        AP_DEC: begin
          if (WRAP || sel_q != '0) sel_d = sel_q - 1'b1;
        end
        AP_PUSH: begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            push  = 1'b1;
            sel_d = bus.cmd_data;
          end
        end
        AP_POP: begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            pop   = 1'b1;
            sel_d = top;
          end
        end
        AP_XCHG: begin
          // The stack top is overwritten with the old pointer in the same edge.
          if (empty) begin
            err_d = 1'b1;
          end else begin
            xchg  = 1'b1;
            sel_d = top;
          end
        end
        AP_CLR_ERR: err_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= SEL_W'(RESET_SEL);
      err_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      err_q <= err_d;
    end
  end

  ap_lifo #(
    .Width (SEL_W),
    .Depth (STACK_DEPTH)
  ) u_lifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .pop_i     (pop),
    .replace_i (xchg),
    .wdata_i   (sel_q),
    .top_o     (top),
    .cnt_o     (bus.stack_cnt),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign bus.ap_sel      = sel_q;
  assign bus.err         = err_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;

endmodule

// File: tb/tb_ap_ptr_unit.sv
// Bench for ap_ptr_unit: a WRAP=1 and a WRAP=0 instance driven in lockstep,
// checked against directed vector tables and a queue-based reference model.
module tb_ap_ptr_unit;
  import ap_pkg::*;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned DEPTH = 4;
  localparam int          N     = 1 << SEL_W;

  typedef struct {
    int w;     // 0: WRAP=1 instance, 1: WRAP=0 instance
    bit v;
    int op;
    int d;
    int sel;
    int cnt;
    bit err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int msel [2];
  bit merr [2];
  int stk0 [$];
  int stk1 [$];

  ap_ptr_unit_if #(.SEL_W(SEL_W), .STACK_DEPTH(DEPTH)) ifa ();
  ap_ptr_unit_if #(.SEL_W(SEL_W), .STACK_DEPTH(DEPTH)) ifb ();

  ap_ptr_unit #(.SEL_W(SEL_W), .STACK_DEPTH(DEPTH), .WRAP(1'b1), .RESET_SEL(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  ap_ptr_unit #(.SEL_W(SEL_W), .STACK_DEPTH(DEPTH), .WRAP(1'b0), .RESET_SEL(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int w, bit v, int op, int d, int sel, int cnt, bit err);
    vec_t r;
    r.w = w; r.v = v; r.op = op; r.d = d; r.sel = sel; r.cnt = cnt; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int w, input string tag, input int esel, input int ecnt,
                           input bit eerr);
    int asel, acnt, afull, aempty, aerr;
    if (w == 0) begin
      asel = int'(ifa.ap_sel); acnt = int'(ifa.stack_cnt); afull = int'(ifa.stack_full);
      aempty = int'(ifa.stack_empty); aerr = int'(ifa.err);
    end else begin
      asel = int'(ifb.ap_sel); acnt = int'(ifb.stack_cnt); afull = int'(ifb.stack_full);
      aempty = int'(ifb.stack_empty); aerr = int'(ifb.err);
    end
    chk({tag, " sel"}, asel, esel);
    chk({tag, " cnt"}, acnt, ecnt);
    chk({tag, " full"}, afull, int'(ecnt == DEPTH));
    chk({tag, " empty"}, aempty, int'(ecnt == 0));
    chk({tag, " err"}, aerr, int'(eerr));
  endtask

  task automatic model_reset();
    msel[0] = 0; msel[1] = 0;
    merr[0] = 1'b0; merr[1] = 1'b0;
    stk0.delete(); stk1.delete();
  endtask

  task automatic model_apply(input int w, input bit v, input int op, input int d);
    int  s [$];
    int  sel, t;
    bit  e, wrap;
    wrap = (w == 0);
    sel  = msel[w];
    e    = merr[w];
    if (w == 0) s = stk0; else s = stk1;
    if (v) begin
      case (op)
        1: sel = d;
        2: sel = wrap ? (sel + 1) % N : ((sel == N - 1) ? sel : sel + 1);
        3: sel = wrap ? (sel + N - 1) % N : ((sel == 0) ? 0 : sel - 1);
        4: if (s.size() == DEPTH) e = 1'b1;
           else begin s.push_back(sel); sel = d; end
        5: if (s.size() == 0) e = 1'b1;
           else sel = s.pop_back();
        6: if (s.size() == 0) e = 1'b1;
           else begin t = s.pop_back(); s.push_back(sel); sel = t; end
        7: e = 1'b0;
        default: ;
      endcase
    end
    msel[w] = sel;
    merr[w] = e;
    if (w == 0) stk0 = s; else stk1 = s;
  endtask

  task automatic drive(input bit v, input int op, input int d);
    ifa.cmd_valid = v; ifa.cmd_op = 3'(op); ifa.cmd_data = 3'(d);
    ifb.cmd_valid = v; ifb.cmd_op = 3'(op); ifb.cmd_data = 3'(d);
  endtask

  // One command per cycle; both instances are checked against the model after the edge.
  task automatic step(input bit v, input int op, input int d);
    drive(v, op, d);
    @(posedge clk);
    #1;
    model_apply(0, v, op, d);
    model_apply(1, v, op, d);
    check_dut(0, "model wrap1", msel[0], stk0.size(), merr[0]);
    check_dut(1, "model wrap0", msel[1], stk1.size(), merr[1]);
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    step(t.v, t.op, t.d);
    check_dut(t.w, $sformatf("vec%0d", idx), t.sel, t.cnt, t.err);
  endtask

  vec_t vecs [$];
  int   split;

  initial begin
    // Scenario 1: wrap on increment.
    vecs.push_back(mk(0, 1, 1, 5, 5, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 6, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 7, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0));
    // Scenario 2: saturation on the WRAP=0 instance.
    vecs.push_back(mk(1, 1, 1, 7, 7, 0, 0));
    vecs.push_back(mk(1, 1, 2, 0, 7, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0));
    // Scenario 3: push overflow, pop drain, pop underflow.
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 4, 2, 2, 1, 0));
    vecs.push_back(mk(0, 1, 4, 3, 3, 2, 0));
    vecs.push_back(mk(0, 1, 4, 4, 4, 3, 0));
    vecs.push_back(mk(0, 1, 4, 5, 5, 4, 0));
    vecs.push_back(mk(0, 1, 4, 6, 5, 4, 1));
    vecs.push_back(mk(0, 1, 5, 0, 4, 3, 1));
    vecs.push_back(mk(0, 1, 5, 0, 3, 2, 1));
    vecs.push_back(mk(0, 1, 5, 0, 2, 1, 1));
    vecs.push_back(mk(0, 1, 5, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 5, 0, 1, 0, 1));
    // Scenario 4: clear, XCHG on empty, then a real exchange.
    vecs.push_back(mk(0, 1, 7, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 6, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 7, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2, 2, 0, 0));
    vecs.push_back(mk(0, 1, 4, 6, 6, 1, 0));
    vecs.push_back(mk(0, 1, 6, 0, 2, 1, 0));
    vecs.push_back(mk(0, 1, 5, 0, 6, 0, 0));
    split = vecs.size();
    // Scenario 6: idle with stale LOAD held, then back-to-back commands.
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 6, 7, 0, 0));
    vecs.push_back(mk(0, 1, 1, 3, 3, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 4, 0, 0));
    vecs.push_back(mk(0, 1, 4, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 5, 0, 4, 0, 0));

    drive(0, 0, 0);
    rst = 1'b1;
    model_reset();
    #1;
    check_dut(0, "reset wrap1", 0, 0, 0);
    check_dut(1, "reset wrap0", 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < split; i++) run_vec(vecs[i], i);

    // Scenario 5: asynchronous reset mid-cycle with three saved entries.
    step(1, 4, 2);
    step(1, 4, 3);
    step(1, 4, 4);
    check_dut(0, "pre-reset", 4, 3, 0);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_dut(0, "async reset wrap1", 0, 0, 0);
    check_dut(1, "async reset wrap0", 0, 0, 0);
    drive(1, 1, 7);
    @(posedge clk);
    #1;
    check_dut(0, "cmd during reset", 0, 0, 0);
    rst = 1'b0;
    step(1, 1, 7);
    check_dut(0, "first cmd after reset", 7, 0, 0);

    for (int i = split; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Randomized traffic against the reference model on both instances.
    for (int i = 0; i < 600; i++) begin
      bit v;
      v = ($urandom_range(0, 9) != 0);
      step(v, int'($urandom_range(0, 7)), int'($urandom_range(0, N - 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ap_ptr_unit.md
Name: ap_ptr_unit

Overview:
- Parametrised successor to the CPU's accumulator-pointer select latch.
- Holds the current register-select pointer that drives operand/destination register selection in the soft CPU datapath.
- Adds increment/decrement with wrap or saturate, a LIFO save stack (push/pop/exchange) for nested pointer contexts, and sticky error reporting.
- Sits between the instruction decoder (command source) and the register file (pointer consumer).

Parameters:
SEL_W, 3, pointer width; the pointer addresses N = 2**SEL_W registers
STACK_DEPTH, 4, number of saved-pointer stack entries (>=1)
WRAP, 1, 1 = INC/DEC wrap modulo N; 0 = saturate at 0 and N-1
RESET_SEL, 0, pointer value after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command strobe; command is consumed on the clk edge where this is 1
cmd_op  in  3  opcode: 0 NOP, 1 LOAD, 2 INC, 3 DEC, 4 PUSH, 5 POP, 6 XCHG, 7 CLR_ERR
cmd_data  in  SEL_W  load value for LOAD and PUSH
ap_sel  out  SEL_W  current pointer (registered)
stack_cnt  out  clog2(STACK_DEPTH+1)  number of occupied stack entries
stack_full  out  1  stack_cnt == STACK_DEPTH
stack_empty  out  1  stack_cnt == 0
err  out  1  sticky error flag

Behaviour:
- Reset values (asynchronous): ap_sel = RESET_SEL; stack_cnt = 0; stack_empty = 1; stack_full = 0; err = 0. Stack contents are don't-care.
- All outputs are registered. A command takes effect on the clk edge where cmd_valid = 1 and is visible the following cycle (latency 1).
- There is no back-pressure: every command is accepted.
- cmd_valid = 0, or NOP: no state changes.
- LOAD: ap_sel <= cmd_data.
- INC:
  - WRAP = 1: ap_sel <= (ap_sel + 1) mod N, so N-1 -> 0.
  - WRAP = 0: N-1 holds at N-1.
  - No error in either case.
- DEC:
  - WRAP = 1: 0 -> N-1.
  - WRAP = 0: 0 holds at 0.
  - No error in either case.
- PUSH:
  - Not full: stack[stack_cnt] <= ap_sel; stack_cnt++; ap_sel <= cmd_data.
  - Full: no state change except err <= 1.
- POP:
  - Not empty: ap_sel <= stack[stack_cnt-1]; stack_cnt--.
  - Empty: no state change except err <= 1.
- XCHG:
  - Not empty: ap_sel and stack[stack_cnt-1] swap in one cycle; stack_cnt is unchanged.
  - Empty: err <= 1, nothing else changes.
- CLR_ERR: err <= 0. No other effect.
- err is sticky. It clears only on CLR_ERR or reset. A new error raised while err = 1 keeps err = 1.
- stack_full and stack_empty are derived combinationally from the registered stack_cnt. They update in the same cycle as stack_cnt.
- Back-to-back commands on consecutive cycles are fully supported. Each command sees the state left by the previous one; there is no forwarding hazard.
- Reset asserted mid-sequence returns everything to reset values immediately. Any command in flight at that edge is discarded.
- cmd_op and cmd_data are ignored while cmd_valid = 0.
- Widths: all pointer arithmetic is SEL_W bits. There is no carry out.

Decomposition:
- Shared package ap_pkg holds:
  - the opcode constants (AP_NOP ... AP_CLR_ERR);
  - the opcode width constant AP_OP_W = 3.
- The decoder and this block both import ap_pkg.
- One sub-module, ap_lifo: the stack storage plus counter, with push/pop/replace-top ports and full/empty outputs.
- The pointer register and opcode decode live in ap_ptr_unit.

Test Plan:
1. Reset, then LOAD 5, then INC ×3 (SEL_W = 3, WRAP = 1) -> ap_sel = 5, 6, 7, 0; err = 0 throughout.
2. WRAP = 0 build: LOAD 7, INC -> ap_sel stays 7; then LOAD 0, DEC -> ap_sel stays 0; err = 0.
3. Push overflow:
   - Stimulus: LOAD 1; PUSH 2; PUSH 3; PUSH 4; PUSH 5; PUSH 6.
   - Required: stack_cnt = 1, 2, 3, 4; stack_full = 1 after the 4th push; 5th push gives err = 1 with ap_sel held at 5.
   - Then POP ×4 -> ap_sel = 4, 3, 2, 1; stack_empty = 1.
   - Then POP once more -> err stays 1; ap_sel stays 1.
4. CLR_ERR after scenario 3 -> err = 0. Then XCHG on empty stack -> err = 1.
   - Then CLR_ERR; LOAD 2; PUSH 6; XCHG -> ap_sel = 2 and top of stack = 6.
   - Then POP -> ap_sel = 6.
5. Assert rst asynchronously (mid-cycle) with stack_cnt = 3 and ap_sel = 4 -> outputs go to RESET_SEL/0 without waiting for a clock edge; the command presented at the next edge after reset release executes normally.
6. cmd_valid = 0 with cmd_op = LOAD and cmd_data = 6 held for 5 cycles -> no output changes. Then a back-to-back LOAD 3, INC, PUSH 0, POP on consecutive cycles -> ap_sel = 3, 4, 0, 4.
